// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: steers the 4:1 operand mux, captures A then B.
// Define OPFETCH_SAME_SRC_EN to fold src_a==src_b fetches into 2 cycles.
module operand_fetch_ctrl #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] src_a,
  input  logic [SEL_W-1:0] src_b,
  input  logic [WIDTH-1:0] mux_q,
  input  logic             ready,
  output logic [SEL_W-1:0] mux_s,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEL_A,
    SEL_B,
    HOLD
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_b;
  logic             take;
`ifdef OPFETCH_SAME_SRC_EN
  logic             same;
`endif

  // A new fetch is accepted from IDLE, or from HOLD as the pair drains.
  always_comb begin
    take = 1'b0;
    unique case (1'b1)
      state == IDLE:          take = start;
      state == HOLD && ready: take = start;
      default:                take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_b <= '0;
      mux_s <= '0;
      opa   <= '0;
      opb   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
`ifdef OPFETCH_SAME_SRC_EN
      same  <= 1'b0;
`endif
    end else if (take) begin
      state <= SEL_A;
      sel_b <= src_b;
      mux_s <= src_a;
      valid <= 1'b0;
      busy  <= 1'b1;
`ifdef OPFETCH_SAME_SRC_EN
      same  <= (src_a == src_b);
`endif
    end else begin
      unique case (state)
        IDLE: begin
        end
        SEL_A: begin
          opa <= mux_q;
`ifdef OPFETCH_SAME_SRC_EN
          if (same) begin
            opb   <= mux_q;
            valid <= 1'b1;
            state <= HOLD;
          end else begin
            mux_s <= sel_b;
            state <= SEL_B;
          end
`else
          mux_s <= sel_b;
          state <= SEL_B;
`endif
        end
        SEL_B: begin
          opb   <= mux_q;
          valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: directed cases plus random traffic
// against a transaction-level model of the fetch sequence.
module tb_operand_fetch_ctrl;

`ifdef OPFETCH_SAME_SRC_EN
  localparam bit SAME = 1'b1;
`else
  localparam bit SAME = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [7:0] mux_q;
  logic       ready;
  logic [1:0] mux_s;
  logic [7:0] opa;
  logic [7:0] opb;
  logic       valid;
  logic       busy;

  logic [7:0] in_v [4];
  assign mux_q = in_v[mux_s];

  operand_fetch_ctrl #(.WIDTH(8), .SEL_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .src_a (src_a),
    .src_b (src_b),
    .mux_q (mux_q),
    .ready (ready),
    .mux_s (mux_s),
    .opa   (opa),
    .opb   (opb),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // transaction model: a fetch is alive from acceptance until handshake
  bit       m_act;
  int       m_age;
  int       m_lat;
  bit [1:0] m_a, m_b, m_mux;
  bit [7:0] m_opa, m_opb;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h",
               name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_age = 0; m_lat = 3;
    m_a = 0; m_b = 0; m_mux = 0;
    m_opa = 0; m_opb = 0;
  endtask

  function automatic bit m_valid();
    return m_act && (m_age >= m_lat - 1);
  endfunction

  task automatic model_step();
    bit vld, acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    vld = m_valid();
    acc = start && (!m_act || (vld && ready));
    if (acc) begin
      m_act = 1; m_age = 0;
      m_a = src_a; m_b = src_b; m_mux = src_a;
      m_lat = (SAME && src_a == src_b) ? 2 : 3;
    end else if (vld && ready) begin
      m_act = 0;
    end else if (m_act && !vld) begin
      m_age++;
      if (m_age == 1 && m_lat == 3) m_mux = m_b;
      if (m_age == m_lat - 1) begin
        m_opa = in_v[m_a];
        m_opb = in_v[m_b];
      end
    end
  endtask

  task automatic compare();
    chk("valid", valid, m_valid());
    chk("busy", busy, m_act);
    chk("mux_s", mux_s, m_mux);
    if (m_valid() || !m_act) begin
      chk("opa", opa, m_opa);
      chk("opb", opb, m_opb);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(bit s, bit [1:0] a, bit [1:0] b, bit r);
    start = s; src_a = a; src_b = b; ready = r;
  endtask

  int lat;
  int guard;

  initial begin
    in_v[0] = 8'h11; in_v[1] = 8'h22;
    in_v[2] = 8'h33; in_v[3] = 8'h44;
    lat = SAME ? 2 : 3;
    drive(0, 0, 0, 0);
    rst_n = 0;
    model_reset();
    tick(); tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_busy_lit", busy, 0);
      chk("rst_opa_lit", opa, 0);
    end

    // basic fetch
    drive(1, 2'b10, 2'b01, 0);
    tick();
    chk("basic_ms0_lit", mux_s, 2'b10);
    drive(0, 0, 0, 0);
    tick();
    chk("basic_ms1_lit", mux_s, 2'b01);
    tick();
    chk("basic_vld_lit", valid, 1);
    chk("basic_opa_lit", opa, 8'h33);
    chk("basic_opb_lit", opb, 8'h22);
    for (int i = 0; i < 4; i++) tick();
    drive(0, 0, 0, 1);
    tick();
    chk("basic_idle_lit", busy, 0);
    drive(0, 0, 0, 0);
    tick();

    // back-to-back
    drive(1, 2'b10, 2'b01, 0);
    tick();
    drive(0, 0, 0, 0);
    tick(); tick(); tick();
    drive(1, 2'b11, 2'b00, 1);
    tick();
    chk("b2b_gap_lit", valid, 0);
    chk("b2b_busy_lit", busy, 1);
    drive(0, 0, 0, 0);
    tick(); tick();
    chk("b2b_vld_lit", valid, 1);
    chk("b2b_opa_lit", opa, 8'h44);
    chk("b2b_opb_lit", opb, 8'h11);
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();

    // start ignored while in SEL_B
    drive(1, 2'b10, 2'b01, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    drive(1, 2'b00, 2'b00, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("ign_opa_lit", opa, 8'h33);
    tick(); tick();
    drive(0, 0, 0, 1);
    tick();
    chk("ign_idle_lit", busy, 0);
    drive(0, 0, 0, 0);
    tick(); tick();
    chk("ign_novld_lit", valid, 0);

    // asynchronous reset in SEL_A
    drive(1, 2'b10, 2'b11, 0);
    tick();
    drive(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_busy_lit", busy, 0);
    chk("arst_ms_lit", mux_s, 0);
    chk("arst_opa_lit", opa, 0);
    chk("arst_vld_lit", valid, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    drive(1, 2'b01, 2'b01, 0);
    for (int i = 0; i < lat - 1; i++) begin
      tick();
      drive(0, 0, 0, 0);
      chk("arst_early_lit", valid, 0);
    end
    tick();
    chk("arst_vld2_lit", valid, 1);
    chk("arst_opa2_lit", opa, 8'h22);
    chk("arst_opb2_lit", opb, 8'h22);
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();

    // same source
    drive(1, 2'b11, 2'b11, 0);
    tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < lat - 1; i++) tick();
    chk("same_vld_lit", valid, 1);
    chk("same_opa_lit", opa, 8'h44);
    chk("same_ms_lit", mux_s, 2'b11);
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();

    // random traffic with fresh mux data
    for (int k = 0; k < 4; k++) in_v[k] = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) != 0),
            2'($urandom), 2'($urandom),
            ($urandom_range(0, 2) == 0));
      tick();
    end

    // drain, bounded
    drive(0, 0, 0, 1);
    guard = 0;
    while (busy && guard < 20) begin
      tick();
      guard++;
    end
    chk("drain_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
